// File: rtl/uart_debug_axi_slave_pkg.sv
// Shared definitions for the debug-download AXI3 SRAM responder:
// response codes, burst encodings, transfer size and FSM states.
package uart_debug_axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [2:0] SIZE_WORD   = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_DATA,
    ST_W_RESP,
    ST_R_FETCH,
    ST_R_DATA
  } state_t;

  // Only full-word transfers with FIXED or INCR bursts are serviced.
  function automatic logic req_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) || burst[1];
  endfunction

endpackage

// File: rtl/uart_debug_axi_slave_sram.sv
// Single-port 2^ADDR_W x 32 RAM: per-byte write enables, registered read.
// Contents are never reset.
module uart_debug_sram #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/uart_debug_axi_slave.sv
// AXI3 responder in front of a word-addressed SRAM; one transaction in flight,
// single-beat and FIXED/INCR bursts up to 16 beats, SLVERR on unsupported requests.
module uart_debug_axi_slave
  import uart_debug_axi_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned ID_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready
);

  state_t            state, state_nx;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_next;
  logic [3:0]        len_q;
  logic [3:0]        beat_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic              last_beat;
  logic [3:0]        sram_we;
  logic [31:0]       sram_rdata;

  logic unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid,
                       awaddr[31:ADDR_W+2], awaddr[1:0],
                       araddr[31:ADDR_W+2], araddr[1:0]};

  assign last_beat = (beat_q == len_q);
  // INCR wraps naturally at 2^ADDR_W; FIXED (and rejected bursts) hold.
  assign addr_next = (burst_q == BURST_INCR) ? addr_q + ADDR_W'(1) : addr_q;

  // The FSM is the only port user; the address is always the latched one.
  uart_debug_sram #(.ADDR_W(ADDR_W)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (addr_q),
    .wdata (wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    arready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bid      = '0;
    bresp    = RESP_OKAY;
    rvalid   = 1'b0;
    rid      = '0;
    rdata    = '0;
    rresp    = RESP_OKAY;
    rlast    = 1'b0;
    sram_we  = '0;
    case (state)
      ST_IDLE: begin
        awready = 1'b1;
        arready = ~awvalid;
        if (awvalid)      state_nx = ST_W_DATA;
        else if (arvalid) state_nx = ST_R_FETCH;
      end
      ST_W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          if (!err_q)    sram_we  = wstrb;
          if (last_beat) state_nx = ST_W_RESP;
        end
      end
      ST_W_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) state_nx = ST_IDLE;
      end
      ST_R_FETCH: state_nx = ST_R_DATA;
      ST_R_DATA: begin
        // SRAM address is frozen here and nothing writes, so rdata holds.
        rvalid = 1'b1;
        rid    = id_q;
        rdata  = err_q ? '0 : sram_rdata;
        rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        rlast  = last_beat;
        if (rready) state_nx = last_beat ? ST_IDLE : ST_R_FETCH;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= BURST_FIXED;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_q <= '0;
          if (awvalid) begin
            id_q    <= awid;
            addr_q  <= awaddr[ADDR_W+1:2];
            len_q   <= awlen;
            burst_q <= awburst;
            err_q   <= req_err(awsize, awburst);
          end else if (arvalid) begin
            id_q    <= arid;
            addr_q  <= araddr[ADDR_W+1:2];
            len_q   <= arlen;
            burst_q <= arburst;
            err_q   <= req_err(arsize, arburst);
          end
        end
        ST_W_DATA: begin
          if (wvalid) begin
            // A misplaced wlast flags the burst but the beat count still rules.
            if (wlast != last_beat) err_q <= 1'b1;
            if (!last_beat) begin
              beat_q <= beat_q + 4'd1;
              addr_q <= addr_next;
            end
          end
        end
        ST_R_DATA: begin
          if (rready && !last_beat) begin
            beat_q <= beat_q + 4'd1;
            addr_q <= addr_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_debug_axi_slave.sv
// Randomized bench for uart_debug_axi_slave against a transaction-level
// memory/response model, plus directed scenarios with literal expectations.
module tb_uart_debug_axi_slave;

  localparam int DEPTH = 16384;
  localparam int TMO   = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, wid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [3:0]  awlen = '0, arlen = '0, wstrb = '0, awcache = '0, arcache = '0;
  logic [2:0]  awsize = '0, arsize = '0, awprot = '0, arprot = '0;
  logic [1:0]  awburst = '0, arburst = '0, awlock = '0, arlock = '0, bresp, rresp;
  logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
  logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
  logic        rlast, rvalid, rready = 1'b0;

  uart_debug_axi_slave #(.ADDR_W(14), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic [31:0] mask; logic last; } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];

  // Reference memory, with per-byte "known" flags for never-written words.
  logic [31:0] mem_m [DEPTH];
  logic [3:0]  kb_m  [DEPTH];

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_cap  [16];
  logic [1:0]  last_bresp, last_rresp;
  int          b_hs_cyc = -10, ar_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr, input int burst, input int beat);
    int base;
    base = int'(addr >> 2) % DEPTH;
    return (burst == 1) ? (base + beat) % DEPTH : base;
  endfunction

  function automatic logic pick_rready(input int mode, input logic cur);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ~cur;
    return 1'($urandom_range(0, 1));
  endfunction

  // Response checker: every cycle a valid is up, it must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b unexpected: got bvalid=1 expected no response pending");
        end else begin
          check("b id", 32'(bid), 32'(exp_b[0].id));
          check("b resp", 32'(bresp), 32'(exp_b[0].resp));
          if (bready) begin void'(exp_b.pop_front()); b_hs_cyc = cyc; end
        end
      end
      if (rvalid) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r unexpected: got rvalid=1 expected no beat pending");
        end else begin
          check("r id", 32'(rid), 32'(exp_r[0].id));
          check("r resp", 32'(rresp), 32'(exp_r[0].resp));
          check("r last", 32'(rlast), 32'(exp_r[0].last));
          if (exp_r[0].mask != 0)
            check("r data", rdata & exp_r[0].mask, exp_r[0].data & exp_r[0].mask);
          if (rready) void'(exp_r.pop_front());
        end
      end
    end
  end

  // Write: model update, AW, W beats (optional bad wlast / reset abort), B with delay.
  task automatic do_write(input int id, input logic [31:0] addr, input int len, input int size,
                          input int burst, input int bdly, input int bad_wl, input int abort_at);
    logic err;
    int w, n;
    err = (size != 2) || (burst >= 2);
    for (int b = 0; b <= len; b++) begin
      if (abort_at >= 0 && b > abort_at) break;
      w = word_of(addr, burst, b);
      if (!err)
        for (int k = 0; k < 4; k++)
          if (wr_strb[b][k]) begin
            mem_m[w][8*k +: 8] = wr_data[b][8*k +: 8];
            kb_m[w][k] = 1'b1;
          end
      if (b == bad_wl) err = 1'b1;
    end
    if (abort_at < 0) exp_b.push_back('{4'(id), err ? 2'b10 : 2'b00});

    awid = 4'(id); awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < TMO) begin @(negedge clk); n++; end
    check("aw accepted in idle", 32'(n), 32'd0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wvalid = 1'b1; wdata = wr_data[b]; wstrb = wr_strb[b];
      wlast = (b == len) ^ (b == bad_wl);
      n = 0;
      @(negedge clk);
      while (!wready && n < TMO) begin @(negedge clk); n++; end
      if (b == 0) check("w first beat latency", 32'(n), 32'd0);
      @(posedge clk); #1;
      if (b == abort_at) begin
        wvalid = 1'b0; wlast = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort bvalid", 32'(bvalid), 32'd0);
        check("abort awready", 32'(awready), 32'd1);
        check("abort wready", 32'(wready), 32'd0);
        @(posedge clk); #1;
        return;
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = (bdly == 0);
    @(negedge clk);
    check("b latency", 32'(bvalid), 32'd1);
    for (int i = 1; i <= bdly; i++) begin
      @(posedge clk); #1;
      if (i == bdly) bready = 1'b1;
      @(negedge clk);
      check("b held", 32'(bvalid), 32'd1);
    end
    last_bresp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Read: AR, then per beat rvalid must appear exactly 2 cycles after the previous handshake.
  task automatic do_read(input int id, input logic [31:0] addr, input int len, input int size,
                         input int burst, input int rmode, input int imm);
    logic err;
    int w, n, gap, done;
    logic seen;
    arid = 4'(id); araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1; rready = 1'b0;
    n = 0;
    @(negedge clk);
    if (!imm) check("ar blocked by aw", 32'(arready), 32'd0);
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    if (imm) check("ar accepted in idle", 32'(n), 32'd0);
    else     check("ar after b handshake", 32'(cyc), 32'(b_hs_cyc + 1));
    err = (size != 2) || (burst >= 2);
    for (int b = 0; b <= len; b++) begin
      r_exp_t e;
      w = word_of(addr, burst, b);
      e.id = 4'(id); e.resp = err ? 2'b10 : 2'b00; e.last = (b == len);
      if (err) begin
        e.data = '0; e.mask = '1;
      end else begin
        e.data = mem_m[w];
        for (int k = 0; k < 4; k++) e.mask[8*k +: 8] = kb_m[w][k] ? 8'hFF : 8'h00;
      end
      exp_r.push_back(e);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = pick_rready(rmode, 1'b0);
    done = 0; gap = 0; seen = 1'b0; n = 0;
    while (done <= len && n < 40 * (len + 1) + 50) begin
      @(negedge clk);
      gap++; n++;
      if (rvalid) begin
        if (!seen) begin check("r beat latency", 32'(gap), 32'd2); seen = 1'b1; end
        if (rready) begin
          rd_cap[done] = rdata; last_rresp = rresp;
          done++; gap = 0; seen = 1'b0;
        end
      end
      @(posedge clk); #1;
      rready = pick_rready(rmode, rready);
    end
    if (done <= len) begin
      checks++; errors++;
      $display("FAIL r timeout: got %0d beats expected %0d", done, len + 1);
    end
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; kb_m[i] = '0; end
    for (int i = 0; i < 16; i++) begin wr_data[i] = '0; wr_strb[i] = 4'hF; rd_cap[i] = '0; end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset awready", 32'(awready), 32'd1);
    check("reset arready", 32'(arready), 32'd1);
    check("reset wready", 32'(wready), 32'd0);
    check("reset bvalid", 32'(bvalid), 32'd0);
    check("reset rvalid", 32'(rvalid), 32'd0);
    check("reset rlast", 32'(rlast), 32'd0);
    check("reset ids", 32'({bid, rid}), 32'd0);
    check("reset resps", 32'({bresp, rresp}), 32'd0);
    check("reset rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // Single write then read, aliased address -> word 4.
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    do_write(2, 32'h1C000010, 0, 2, 1, 0, -1, -1);
    check("t1 bresp", 32'(last_bresp), 32'd0);
    do_read(2, 32'h1C000010, 0, 2, 1, 0, 1);
    check("t1 rdata", rd_cap[0], 32'hDEADBEEF);

    // Byte strobes on word 8.
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
    do_write(5, 32'h20, 0, 2, 1, 0, -1, -1);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    do_write(5, 32'h20, 0, 2, 1, 1, -1, -1);
    check("t2 model pin", mem_m[8], 32'h11BB33DD);
    do_read(6, 32'h20, 0, 2, 1, 0, 1);
    check("t2 rdata", rd_cap[0], 32'h11BB33DD);

    // INCR read burst with rready toggling.
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(1, 32'h0, 3, 2, 1, 0, -1, -1);
    do_read(3, 32'h0, 3, 2, 1, 1, 1);
    for (int i = 0; i < 4; i++) check("t3 burst beat", rd_cap[i], 32'hA0 + 32'(i));

    // Simultaneous AW/AR, B backpressure for 5 cycles.
    wr_data[0] = 32'h0BADF00D; wr_strb[0] = 4'hF;
    fork
      do_write(9, 32'h30, 0, 2, 1, 5, -1, -1);
      do_read(10, 32'h30, 0, 2, 1, 0, 0);
    join
    check("t4 read sees write", rd_cap[0], 32'h0BADF00D);

    // Error cases.
    wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
    do_write(4, 32'h40, 0, 2, 1, 0, -1, -1);
    wr_data[0] = 32'hFFFFFFFF;
    do_write(4, 32'h40, 0, 1, 1, 0, -1, -1);
    check("t5 size err bresp", 32'(last_bresp), 32'd2);
    do_read(4, 32'h40, 0, 2, 1, 0, 1);
    check("t5 memory unchanged", rd_cap[0], 32'h12345678);
    do_read(7, 32'h10, 0, 2, 2, 0, 1);
    check("t5 wrap burst rresp", 32'(last_rresp), 32'd2);
    check("t5 wrap burst rdata", rd_cap[0], 32'd0);
    wr_data[0] = 32'h5555AAAA; wr_data[1] = 32'h6666BBBB;
    do_write(8, 32'h34, 1, 2, 1, 0, 0, -1);
    check("t5 early wlast bresp", 32'(last_bresp), 32'd2);

    // Reset in the middle of an 8-beat write burst at word 64.
    for (int i = 0; i < 8; i++) begin wr_data[i] = 32'hC0DE0000 + 32'(i); wr_strb[i] = 4'hF; end
    do_write(11, 32'h100, 7, 2, 1, 0, -1, 3);
    do_read(11, 32'h100, 7, 2, 1, 0, 1);
    for (int i = 0; i < 4; i++) check("t6 partial burst kept", rd_cap[i], 32'hC0DE0000 + 32'(i));

    // Randomized traffic: small window plus the top of memory for INCR wrap.
    for (int t = 0; t < 80; t++) begin
      int len, size, burst, word, id;
      logic [31:0] addr;
      id    = $urandom_range(0, 15);
      len   = $urandom_range(0, 15);
      size  = ($urandom_range(0, 9) == 0) ? 1 : 2;
      burst = ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1);
      word  = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 6, DEPTH - 1)
                                          : $urandom_range(0, 63);
      addr  = ($urandom() & 32'hFFFF0000) | (32'(word) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) begin
          wr_data[i] = $urandom();
          wr_strb[i] = 4'($urandom_range(0, 15));
        end
        do_write(id, addr, len, size, burst, $urandom_range(0, 3), -1, -1);
      end else begin
        do_read(id, addr, len, size, burst, 2, 1);
      end
    end

    repeat (4) @(posedge clk);
    check("b queue drained", 32'(exp_b.size()), 32'd0);
    check("r queue drained", 32'(exp_r.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
